// File: rtl/risc_toy_fetch_queue.sv
// -----------------------------------------------------------------------------
// risc_toy_fetch_queue
//
// Instruction-fetch front end for the RISC_TOY pipeline. Issues one read per
// cycle to a synchronous instruction memory (data returns the following cycle),
// buffers the returned words in a DEPTH-entry FIFO and hands them to decode
// over a valid/ready handshake. A redirect from execute flushes the queue,
// drops any response in flight and restarts fetch at the new PC.
//
// Ports:
//   CLK, RSTN        clock (rising edge) and asynchronous active-low reset
//   IREQ, IADDR      instruction memory read request and word address
//   INSTR            instruction data, valid the cycle after IREQ
//   redirect_valid   execute stage requests a PC change
//   redirect_pc      new fetch word address
//   out_valid        out_instr/out_pc hold a valid entry
//   out_ready        decode accepts the entry
//   out_instr        head-of-queue instruction (0 when empty)
//   out_pc           word address of out_instr (0 when empty)
// -----------------------------------------------------------------------------
module risc_toy_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IREQ,
  output logic [29:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [29:0] out_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [29:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [29:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   fifo_instr_q [DEPTH];
  logic [29:0]   fifo_pc_q    [DEPTH];

  logic [CW:0]   occupancy;
  logic          issue;
  logic          push;
  logic          pop;
  logic          not_empty;

  // The in-flight request holds a reserved slot, so a returning word always
  // has room in the FIFO and no overflow check is needed on push.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue     = RSTN && !redirect_valid && (occupancy < DEPTH_V);
  assign not_empty = (count_q != '0);

  assign IREQ      = issue;
  assign IADDR     = fetch_pc_q;
  assign out_valid = not_empty && !redirect_valid;
  assign out_instr = not_empty ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign out_pc    = not_empty ? fifo_pc_q[rd_ptr_q]    : 30'h0;

  // Next-state for the fetch PC, in-flight tracker and FIFO bookkeeping.
  // A redirect overrides everything: the queue empties, the response that
  // arrives this cycle is dropped and fetch restarts at redirect_pc.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    push          = 1'b0;
    pop           = 1'b0;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      push = inflight_q;
      pop  = out_valid && out_ready;

      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 30'd1;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 30'h0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Entry storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= INSTR;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule
